// File: rtl/hazard_unit_pkg.sv
// Shared pipeline definitions: forward-select codes, watchdog states, register-match helper.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package hazard_unit_pkg;

    // E-stage operand mux selects
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic [1:0] {
        WD_RUN  = 2'b00,
        WD_WAIT = 2'b01,
        WD_ERR  = 2'b10
    } wd_state_t;

    // A writing stage matches a source register; $zero never matches
    function automatic logic regHit(input logic wr, input logic [4:0] dst, input logic [4:0] src);
        return wr && (dst != 5'd0) && (dst == src);
    endfunction

endpackage

// File: rtl/hazard_watchdog.sv
// Data-memory wait watchdog: counts consecutive wait cycles, latches a sticky error on timeout.
// Latency: error visible the cycle after the TIMEOUT-th consecutive wait cycle.
// Backpressure: none; it observes memWait only, and ERR holds until reset.
module hazard_watchdog
    import hazard_unit_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic memWait,
    output logic errState,
    output logic busErr
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    wd_state_t     state, stateNext;
    logic [CW-1:0] cnt, cntNext;

    // State and wait-counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WD_RUN;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    // Next state: a ready in the would-trip cycle ends the wait, so it returns to RUN
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        case (state)
            WD_RUN: begin
                if (memWait) begin
                    stateNext = WD_WAIT;
                    cntNext   = CW'(1);
                end
            end
            WD_WAIT: begin
                if (!memWait) begin
                    stateNext = WD_RUN;
                    cntNext   = '0;
                end else if (cnt == LAST) begin
                    stateNext = WD_ERR;
                end else begin
                    cntNext = cnt + CW'(1);
                end
            end
            WD_ERR: begin
                stateNext = WD_ERR;
            end
            default: begin
                stateNext = WD_RUN;
                cntNext   = '0;
            end
        endcase
    end

    assign errState = (state == WD_ERR);
    assign busErr   = errState;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: forwarding selects, stall/flush strobes, memory watchdog, stall counter.
// Latency: stall/flush/forward outputs are combinational; bus_err and stall_cnt are registered.
// Backpressure: dmem wait freezes F/D/E/M and bubbles W; load-use/branch hazards freeze F/D and bubble E.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rsD,
    input  logic [4:0]       rtD,
    input  logic [4:0]       rsE,
    input  logic [4:0]       rtE,
    input  logic [4:0]       writeregE,
    input  logic [4:0]       writeregM,
    input  logic [4:0]       writeregW,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             MemtoRegM,
    input  logic             MemWriteM,
    input  logic             BranchD,
    input  logic             PCSrcD,
    input  logic             dmem_ready,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             ForwardAD,
    output logic             ForwardBD,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             bus_err,
    output logic [CNT_W-1:0] stall_cnt
);

    logic lwStall, brStall, memWait, errState;

    assign memWait = (MemtoRegM || MemWriteM) && !dmem_ready;

    assign lwStall = regHit(MemtoRegE, writeregE, rsD) || regHit(MemtoRegE, writeregE, rtD);

    assign brStall = BranchD &&
                     (regHit(RegWriteE, writeregE, rsD) || regHit(RegWriteE, writeregE, rtD) ||
                      regHit(MemtoRegM, writeregM, rsD) || regHit(MemtoRegM, writeregM, rtD));

    // E-stage forwarding: the younger M result takes precedence over W
    always_comb begin
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        if (regHit(RegWriteM, writeregM, rsE))      ForwardAE = FWD_M;
        else if (regHit(RegWriteW, writeregW, rsE)) ForwardAE = FWD_W;
        if (regHit(RegWriteM, writeregM, rtE))      ForwardBE = FWD_M;
        else if (regHit(RegWriteW, writeregW, rtE)) ForwardBE = FWD_W;
    end

    assign ForwardAD = regHit(RegWriteM, writeregM, rsD);
    assign ForwardBD = regHit(RegWriteM, writeregM, rtD);

    // Stall/flush priority: watchdog error, memory wait, data hazard, taken branch
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (errState || memWait) begin
            // Freeze everything up to M; W gets a bubble so the held M op is not retired twice
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (lwStall || brStall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end else if (PCSrcD) begin
            FlushD = 1'b1;
        end
    end

    hazard_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .memWait  (memWait),
        .errState (errState),
        .busErr   (bus_err)
    );

    // Saturating count of fetch-stall cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (StallF && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4:0]       rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic             RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, MemWriteM;
    logic             BranchD, PCSrcD, dmem_ready;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             ForwardAD, ForwardBD;
    logic             StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, bus_err;
    logic [CNT_W-1:0] stall_cnt;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    hazard_unit #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
        .BranchD(BranchD), .PCSrcD(PCSrcD), .dmem_ready(dmem_ready),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .bus_err(bus_err), .stall_cnt(stall_cnt)
    );

    // Stall/flush vector packed as {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
    wire [6:0] ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

    task automatic idle();
        rsD = 0; rtD = 0; rsE = 0; rtE = 0;
        writeregE = 0; writeregM = 0; writeregW = 0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
        MemtoRegE = 0; MemtoRegM = 0; MemWriteM = 0;
        BranchD = 0; PCSrcD = 0; dmem_ready = 1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        #12;
        vectors++;
        if (bus_err !== 1'b0) begin errors++; $display("FAIL reset_bus_err got %b want 0", bus_err); end
        vectors++;
        if (stall_cnt !== 5'd0) begin errors++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
        vectors++;
        if (ctl !== 7'b0) begin errors++; $display("FAIL reset_ctl got %b want 0000000", ctl); end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_forward();
        @(negedge clk);
        idle();
        writeregM = 5; RegWriteM = 1; rsE = 5; writeregW = 5; RegWriteW = 1;
        #1;
        vectors++;
        if (ForwardAE !== 2'b10) begin errors++; $display("FAIL fwd_m_over_w got %b want 10", ForwardAE); end
        vectors++;
        if (ForwardBE !== 2'b00) begin errors++; $display("FAIL fwd_be_none got %b want 00", ForwardBE); end
        RegWriteM = 0; rtE = 5;
        #1;
        vectors++;
        if (ForwardAE !== 2'b01) begin errors++; $display("FAIL fwd_w got %b want 01", ForwardAE); end
        vectors++;
        if (ForwardBE !== 2'b01) begin errors++; $display("FAIL fwd_be_w got %b want 01", ForwardBE); end
        rsE = 0; writeregW = 0;
        #1;
        vectors++;
        if (ForwardAE !== 2'b00) begin errors++; $display("FAIL fwd_r0 got %b want 00", ForwardAE); end
        RegWriteM = 1; writeregM = 0; rsD = 0;
        #1;
        vectors++;
        if (ForwardAD !== 1'b0) begin errors++; $display("FAIL fwd_ad_r0 got %b want 0", ForwardAD); end
        writeregM = 9; rtD = 9;
        #1;
        vectors++;
        if ({ForwardAD, ForwardBD} !== 2'b01) begin errors++; $display("FAIL fwd_bd got %b want 01", {ForwardAD, ForwardBD}); end
        vectors++;
        if (ctl !== 7'b0) begin errors++; $display("FAIL fwd_no_stall got %b want 0000000", ctl); end
    endtask

    task automatic test_loaduse();
        @(negedge clk);
        idle();
        MemtoRegE = 1; writeregE = 8; rtD = 8; PCSrcD = 1;
        #1;
        vectors++;
        if (ctl !== 7'b1100010) begin errors++; $display("FAIL loaduse_ctl got %b want 1100010", ctl); end
        @(posedge clk); #1;
        vectors++;
        if (stall_cnt !== 5'd1) begin errors++; $display("FAIL loaduse_cnt got %0d want 1", stall_cnt); end
        @(negedge clk);
        idle();
        MemtoRegE = 1; writeregE = 0; rtD = 0;
        #1;
        vectors++;
        if (ctl !== 7'b0) begin errors++; $display("FAIL loaduse_r0 got %b want 0000000", ctl); end
    endtask

    task automatic test_branch();
        @(negedge clk);
        idle();
        BranchD = 1; RegWriteE = 1; writeregE = 3; rsD = 3;
        #1;
        vectors++;
        if (ctl !== 7'b1100010) begin errors++; $display("FAIL branch_stall got %b want 1100010", ctl); end
        @(negedge clk);
        RegWriteE = 0; writeregE = 0; PCSrcD = 1; writeregM = 3; RegWriteM = 1;
        #1;
        vectors++;
        if (ctl !== 7'b0000100) begin errors++; $display("FAIL branch_flushd got %b want 0000100", ctl); end
        vectors++;
        if (ForwardAD !== 1'b1) begin errors++; $display("FAIL branch_fwd_ad got %b want 1", ForwardAD); end
        @(negedge clk);
        idle();
        BranchD = 1; MemtoRegM = 1; writeregM = 7; rtD = 7;
        #1;
        vectors++;
        if (ctl !== 7'b1100010) begin errors++; $display("FAIL branch_load_m got %b want 1100010", ctl); end
        @(posedge clk); #1;
        vectors++;
        if (stall_cnt !== 5'd3) begin errors++; $display("FAIL branch_cnt got %0d want 3", stall_cnt); end
    endtask

    task automatic test_memwait();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            idle();
            MemtoRegM = 1; dmem_ready = 0;
            if (i == 1) begin MemtoRegE = 1; writeregE = 4; rsD = 4; end
            #1;
            vectors++;
            if (ctl !== 7'b1111001) begin errors++; $display("FAIL memwait_c%0d got %b want 1111001", i, ctl); end
        end
        @(negedge clk);
        idle();
        MemtoRegM = 1;
        #1;
        vectors++;
        if (ctl !== 7'b0) begin errors++; $display("FAIL memwait_release got %b want 0000000", ctl); end
        vectors++;
        if (stall_cnt !== 5'd6 || bus_err !== 1'b0) begin
            errors++; $display("FAIL memwait_cnt got %0d/%b want 6/0", stall_cnt, bus_err);
        end
    endtask

    task automatic test_ready_at_trip();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            idle();
            MemWriteM = 1; dmem_ready = 0;
        end
        @(negedge clk);
        dmem_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (bus_err !== 1'b0) begin errors++; $display("FAIL ready_at_trip got %b want 0", bus_err); end
        vectors++;
        if (stall_cnt !== 5'd9) begin errors++; $display("FAIL ready_at_trip_cnt got %0d want 9", stall_cnt); end
    endtask

    task automatic test_watchdog();
        @(negedge clk);
        idle();
        MemtoRegM = 1; dmem_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (bus_err !== 1'b0) begin errors++; $display("FAIL wd_early got %b want 0", bus_err); end
        @(posedge clk); #1;
        vectors++;
        if (bus_err !== 1'b1) begin errors++; $display("FAIL wd_trip got %b want 1", bus_err); end
        vectors++;
        if (stall_cnt !== 5'd13) begin errors++; $display("FAIL wd_cnt got %0d want 13", stall_cnt); end
        @(negedge clk);
        idle();
        MemtoRegE = 1; writeregE = 6; rsD = 6; PCSrcD = 1;
        #1;
        vectors++;
        if (ctl !== 7'b1111001) begin errors++; $display("FAIL wd_err_ctl got %b want 1111001", ctl); end
        repeat (17) @(posedge clk);
        #1;
        vectors++;
        if (stall_cnt !== 5'd30 || bus_err !== 1'b1) begin
            errors++; $display("FAIL wd_sticky got %0d/%b want 30/1", stall_cnt, bus_err);
        end
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (stall_cnt !== 5'd31) begin errors++; $display("FAIL cnt_saturate got %0d want 31", stall_cnt); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        idle();
        #2;
        rst_n = 0;
        #1;
        vectors++;
        if (bus_err !== 1'b0 || stall_cnt !== 5'd0) begin
            errors++; $display("FAIL areset_state got %b/%0d want 0/0", bus_err, stall_cnt);
        end
        vectors++;
        if (ctl !== 7'b0) begin errors++; $display("FAIL areset_ctl got %b want 0000000", ctl); end
        @(negedge clk);
        rst_n = 1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (bus_err !== 1'b0 || ctl !== 7'b0 || stall_cnt !== 5'd0) begin
            errors++; $display("FAIL areset_after got %b/%b/%0d want 0/0000000/0", bus_err, ctl, stall_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_loaduse();
        test_branch();
        test_memwait();
        test_ready_at_trip();
        test_watchdog();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
